// File: rtl/ysyx_25040109_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25040109_pkg
// Shared definitions for the write-back unit:
//   - machine-mode CSR addresses (mstatus, mtvec, mepc, mcause)
//   - mcause code written on an M-mode ecall
//   - write-back FSM state encoding (2-bit)
// ---------------------------------------------------------------------------
package ysyx_25040109_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned MCAUSE_ECALL_M = 11;

  typedef enum logic [1:0] {
    WBU_IDLE       = 2'd0,
    WBU_WRITE      = 2'd1,
    WBU_TRAP_EPC   = 2'd2,
    WBU_TRAP_CAUSE = 2'd3
  } wbu_state_e;

endpackage

// File: rtl/ysyx_25040109_wbu_if.sv
// ---------------------------------------------------------------------------
// ysyx_25040109_wbu_if
// Bundle of every non-clock/reset signal of the write-back unit.
//   Upstream result : in_valid/in_ready handshake, in_pc, GPR/CSR write
//                     requests, in_ecall/in_mret flags
//   CSR snapshot    : mepc_in, mtvec_in from the register file
//   Register file   : rf_wen/rf_waddr/rf_wdata, csr_we/csr_addr/csr_wdata
//   IFU redirect    : redirect_valid/redirect_pc
//   Difftest        : commit_valid/commit_pc
// Modports:
//   slave  - the WBU itself
//   master - the surrounding environment (pipeline, register file, IFU)
// ---------------------------------------------------------------------------
interface ysyx_25040109_wbu_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_pc;
  logic                  in_rd_wen;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic [DATA_WIDTH-1:0] in_rd_data;
  logic                  in_csr_wen;
  logic [11:0]           in_csr_addr;
  logic [DATA_WIDTH-1:0] in_csr_wdata;
  logic                  in_ecall;
  logic                  in_mret;
  logic [DATA_WIDTH-1:0] mepc_in;
  logic [DATA_WIDTH-1:0] mtvec_in;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  csr_we;
  logic [11:0]           csr_addr;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  commit_valid;
  logic [31:0]           commit_pc;

  modport slave (
    input  in_valid, in_pc, in_rd_wen, in_rd, in_rd_data,
           in_csr_wen, in_csr_addr, in_csr_wdata, in_ecall, in_mret,
           mepc_in, mtvec_in,
    output in_ready, rf_wen, rf_waddr, rf_wdata, csr_we, csr_addr, csr_wdata,
           redirect_valid, redirect_pc, commit_valid, commit_pc
  );

  modport master (
    output in_valid, in_pc, in_rd_wen, in_rd, in_rd_data,
           in_csr_wen, in_csr_addr, in_csr_wdata, in_ecall, in_mret,
           mepc_in, mtvec_in,
    input  in_ready, rf_wen, rf_waddr, rf_wdata, csr_we, csr_addr, csr_wdata,
           redirect_valid, redirect_pc, commit_valid, commit_pc
  );

endinterface

// File: rtl/ysyx_25040109_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_25040109_wbu
// Write-back unit in front of the register file. Accepts one retired result
// per in_valid/in_ready handshake, then drives the GPR and CSR write ports,
// sequences the two-CSR ecall trap entry (mepc, then mcause), redirects the
// PC for ecall/mret and pulses commit_valid once per instruction.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - ysyx_25040109_wbu_if.slave (handshake, payload, RF/CSR ports,
//            redirect, commit)
//
// Optional: define WBU_TRACE_EN (non-synthesis builds) to print a line per
// committed instruction.
// ---------------------------------------------------------------------------
module ysyx_25040109_wbu
  import ysyx_25040109_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_25040109_wbu_if.slave        bus
);

  wbu_state_e r_state;
  wbu_state_e w_next_state;

  // Payload captured on handshake; outputs are decoded only from these.
  logic [31:0]           r_pc;
  logic                  r_rd_wen;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_csr_wen;
  logic [11:0]           r_csr_addr;
  logic [DATA_WIDTH-1:0] r_csr_wdata;
  logic                  r_mret;

  logic                  w_hs;
  logic                  w_in_ready;
  logic                  w_rf_wen;
  logic [ADDR_WIDTH-1:0] w_rf_waddr;
  logic [DATA_WIDTH-1:0] w_rf_wdata;
  logic                  w_csr_we;
  logic [11:0]           w_csr_addr;
  logic [DATA_WIDTH-1:0] w_csr_wdata;
  logic                  w_redirect_valid;
  logic [31:0]           w_redirect_pc;
  logic                  w_commit_valid;
  logic [31:0]           w_commit_pc;

  assign w_hs = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WBU_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= '0;
      r_rd_wen    <= 1'b0;
      r_rd        <= '0;
      r_rd_data   <= '0;
      r_csr_wen   <= 1'b0;
      r_csr_addr  <= '0;
      r_csr_wdata <= '0;
      r_mret      <= 1'b0;
    end else if (w_hs) begin
      r_pc        <= bus.in_pc;
      r_rd_wen    <= bus.in_rd_wen;
      r_rd        <= bus.in_rd;
      r_rd_data   <= bus.in_rd_data;
      r_csr_wen   <= bus.in_csr_wen;
      r_csr_addr  <= bus.in_csr_addr;
      r_csr_wdata <= bus.in_csr_wdata;
      r_mret      <= bus.in_mret;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_in_ready       = 1'b0;
    w_rf_wen         = 1'b0;
    w_rf_waddr       = '0;
    w_rf_wdata       = '0;
    w_csr_we         = 1'b0;
    w_csr_addr       = '0;
    w_csr_wdata      = '0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_commit_valid   = 1'b0;
    w_commit_pc      = '0;

    unique case (r_state)
      WBU_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          // ecall takes the trap path; its GPR/CSR requests and any mret
          // flag are never acted on there.
          w_next_state = bus.in_ecall ? WBU_TRAP_EPC : WBU_WRITE;
        end
      end

      WBU_WRITE: begin
        if (r_rd_wen && (r_rd != '0)) begin
          w_rf_wen   = 1'b1;
          w_rf_waddr = r_rd;
          w_rf_wdata = r_rd_data;
        end
        if (r_csr_wen) begin
          w_csr_we    = 1'b1;
          w_csr_addr  = r_csr_addr;
          w_csr_wdata = r_csr_wdata;
        end
        if (r_mret) begin
          w_redirect_valid = 1'b1;
          w_redirect_pc    = 32'(bus.mepc_in);
        end
        w_commit_valid = 1'b1;
        w_commit_pc    = r_pc;
        w_next_state   = WBU_IDLE;
      end

      WBU_TRAP_EPC: begin
        w_csr_we     = 1'b1;
        w_csr_addr   = CSR_MEPC;
        w_csr_wdata  = DATA_WIDTH'(r_pc);
        w_next_state = WBU_TRAP_CAUSE;
      end

      WBU_TRAP_CAUSE: begin
        w_csr_we         = 1'b1;
        w_csr_addr       = CSR_MCAUSE;
        w_csr_wdata      = DATA_WIDTH'(MCAUSE_ECALL_M);
        w_redirect_valid = 1'b1;
        w_redirect_pc    = 32'(bus.mtvec_in);
        w_commit_valid   = 1'b1;
        w_commit_pc      = r_pc;
        w_next_state     = WBU_IDLE;
      end

      default: begin
        w_next_state = WBU_IDLE;
      end
    endcase
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.rf_wen         = w_rf_wen;
  assign bus.rf_waddr       = w_rf_waddr;
  assign bus.rf_wdata       = w_rf_wdata;
  assign bus.csr_we         = w_csr_we;
  assign bus.csr_addr       = w_csr_addr;
  assign bus.csr_wdata      = w_csr_wdata;
  assign bus.redirect_valid = w_redirect_valid;
  assign bus.redirect_pc    = w_redirect_pc;
  assign bus.commit_valid   = w_commit_valid;
  assign bus.commit_pc      = w_commit_pc;

`ifdef WBU_TRACE_EN
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && w_commit_valid) begin
      $display("[wbu] pc=%08h%s%s%s%s",
               w_commit_pc,
               w_rf_wen ? $sformatf(" x%0d=%08h", w_rf_waddr, w_rf_wdata) : "",
               (w_csr_we && r_state == WBU_WRITE)
                 ? $sformatf(" csr[%03h]=%08h", w_csr_addr, w_csr_wdata) : "",
               (r_state == WBU_TRAP_CAUSE) ? " ECALL" : "",
               (r_state == WBU_WRITE && r_mret) ? " MRET" : "");
    end
  end
`endif
`endif

endmodule
